// File: rtl/rast_tri_sched.sv
// Front-end triangle scheduler for rast: round-robin arbitration of two requesters into one
// registered slot, plus screen/subsample config registers applied only after the pipe drains.
module rast_tri_sched #(
  parameter int SIGFIG       = 24,
  parameter int RADIX        = 10,
  parameter int VERTS        = 3,
  parameter int AXIS         = 3,
  parameter int COLORS       = 3,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [1:0]                                          req_valid,
  output logic [1:0]                                          req_ready,
  input  logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  req_tri,
  input  logic [1:0][COLORS-1:0][SIGFIG-1:0]                  req_color,
  input  logic                                                cfg_valid,
  input  logic signed [1:0][SIGFIG-1:0]                       cfg_screen,
  input  logic [3:0]                                          cfg_subSample,
  output logic                                                cfg_ready,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]       tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]                       color_R10U,
  output logic                                                validTri_R10H,
  input  logic                                                halt_RnnnnL,
  output logic signed [1:0][SIGFIG-1:0]                       screen_RnnnnS,
  output logic [3:0]                                          subSample_RnnnnU,
  output logic [31:0]                                         tri_count
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255 || RADIX >= SIGFIG) begin : g_bad_param
    $error("rast_tri_sched: DRAIN_CYCLES must be 1..255 and RADIX below SIGFIG");
  end

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_e;
  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;

  state_e                       state_q, state_d;
  logic [7:0]                   drain_q, drain_d;
  logic                         rr_q, rr_d;
  logic                         valid_q, valid_d;
  tri_t                         tri_q, tri_d;
  color_t                       color_q, color_d;
  logic signed [1:0][SIGFIG-1:0] screen_q, screen_d;
  logic [3:0]                   sub_q, sub_d;
  logic [31:0]                  tri_count_q, tri_count_d;

  logic slot_free, consumed, gnt;

  assign slot_free = !valid_q || halt_RnnnnL;
  assign consumed  = valid_q && halt_RnnnnL;
  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  assign gnt       = (&req_valid) ? rr_q : req_valid[1];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    rr_d        = rr_q;
    valid_d     = valid_q;
    tri_d       = tri_q;
    color_d     = color_q;
    screen_d    = screen_q;
    sub_d       = sub_q;
    tri_count_d = tri_count_q + {31'd0, consumed};
    req_ready   = '0;

    if (consumed) valid_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (slot_free && (|req_valid)) begin
          req_ready[gnt] = 1'b1;
          valid_d        = 1'b1;
          tri_d          = req_tri[gnt];
          color_d        = req_color[gnt];
          rr_d           = ~gnt;
        end
        if (cfg_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q || !halt_RnnnnL) begin
          drain_d = '0;
        end else begin
          drain_d = drain_q + 8'd1;
          if (drain_q == DRAIN_LAST) state_d = APPLY;
        end
      end
      APPLY: begin
        screen_d = cfg_screen;
        sub_d    = cfg_subSample;
        drain_d  = '0;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase

    if (rst) req_ready = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= '0;
      rr_q        <= 1'b0;
      valid_q     <= 1'b0;
      tri_q       <= '0;
      color_q     <= '0;
      screen_q    <= '0;
      sub_q       <= '0;
      tri_count_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      tri_q       <= tri_d;
      color_q     <= color_d;
      screen_q    <= screen_d;
      sub_q       <= sub_d;
      tri_count_q <= tri_count_d;
    end
  end

  assign cfg_ready        = (state_q == APPLY);
  assign tri_R10S         = tri_q;
  assign color_R10U       = color_q;
  assign validTri_R10H    = valid_q;
  assign screen_RnnnnS    = screen_q;
  assign subSample_RnnnnU = sub_q;
  assign tri_count        = tri_count_q;

endmodule

// File: tb/tb_rast_tri_sched.sv
// Directed bench for rast_tri_sched: slot latency, round-robin, backpressure, config drain,
// tri_count wrap and reset during a pending config.
module tb_rast_tri_sched;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [1:0]                    req_valid;
  logic [1:0]                    req_ready;
  logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri;
  logic [1:0][COLORS-1:0][SIGFIG-1:0] req_color;
  logic                          cfg_valid;
  logic signed [1:0][SIGFIG-1:0] cfg_screen;
  logic [3:0]                    cfg_subSample;
  logic                          cfg_ready;
  tri_t                          tri_R10S;
  color_t                        color_R10U;
  logic                          validTri_R10H;
  logic                          halt_RnnnnL;
  logic signed [1:0][SIGFIG-1:0] screen_RnnnnS;
  logic [3:0]                    subSample_RnnnnU;
  logic [31:0]                   tri_count;

  int n_checks = 0;
  int n_errors = 0;

  rast_tri_sched #(.DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tri(req_tri), .req_color(req_color),
    .cfg_valid(cfg_valid), .cfg_screen(cfg_screen), .cfg_subSample(cfg_subSample),
    .cfg_ready(cfg_ready),
    .tri_R10S(tri_R10S), .color_R10U(color_R10U), .validTri_R10H(validTri_R10H),
    .halt_RnnnnL(halt_RnnnnL),
    .screen_RnnnnS(screen_RnnnnS), .subSample_RnnnnU(subSample_RnnnnU),
    .tri_count(tri_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic tri_t mk_tri(input int r, input int n);
    tri_t t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = (r == 0) ? SIGFIG'(n * 10 + v * 3 + a) : SIGFIG'(-(n * 10 + v * 3 + a + 1));
    return t;
  endfunction

  function automatic color_t mk_color(input int r, input int n);
    color_t c;
    for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'(r * 500 + n * 7 + k);
    return c;
  endfunction

  task automatic drive(input logic [1:0] v, input int n);
    req_valid    = v;
    req_tri[0]   = mk_tri(0, n);
    req_tri[1]   = mk_tri(1, n);
    req_color[0] = mk_color(0, n);
    req_color[1] = mk_color(1, n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input int r, input int n);
    tri_t   et;
    color_t ec;
    et = mk_tri(r, n);
    ec = mk_color(r, n);
    check({tag, ".valid"}, 64'(validTri_R10H), 64'd1);
    check({tag, ".v0a0"}, 64'(tri_R10S[0][0]), 64'(et[0][0]));
    check({tag, ".v2a2"}, 64'(tri_R10S[VERTS-1][AXIS-1]), 64'(et[VERTS-1][AXIS-1]));
    check({tag, ".color"}, 64'(color_R10U[COLORS-1]), 64'(ec[COLORS-1]));
  endtask

  initial begin
    rst = 1'b1; halt_RnnnnL = 1'b1; cfg_valid = 1'b0;
    cfg_screen = '0; cfg_subSample = '0;
    drive(2'b11, 0);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    step();
    check("rst_valid", 64'(validTri_R10H), 64'd0);
    check("rst_tri", 64'(tri_R10S[0][0]), 64'd0);
    check("rst_count", 64'(tri_count), 64'd0);
    check("rst_screen", 64'(screen_RnnnnS), 64'd0);
    check("rst_sub", 64'(subSample_RnnnnU), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    drive(2'b00, 0);
    step();

    // Single requester, four back-to-back triangles.
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, k);
      #1;
      check($sformatf("single_ready%0d", k), 64'(req_ready), 64'd1);
      step();
      check_slot($sformatf("single_slot%0d", k), 0, k);
      check($sformatf("single_count%0d", k), 64'(tri_count), 64'(k));
    end
    drive(2'b00, 0);
    #1;
    check("single_idle_ready", 64'(req_ready), 64'd0);
    step();
    check("single_drained", 64'(validTri_R10H), 64'd0);
    check("single_count", 64'(tri_count), 64'd4);

    // Round-robin straight after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 10 + k);
      #1;
      check($sformatf("rr_ready%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      step();
      check_slot($sformatf("rr_slot%0d", k), k % 2, 10 + k);
    end
    drive(2'b00, 0);
    step();
    check("rr_count", 64'(tri_count), 64'd6);

    // Backpressure: slot holds for five halted cycles, then consume and grant together.
    drive(2'b01, 20);
    #1;
    check("bp_first_ready", 64'(req_ready), 64'd1);
    step();
    halt_RnnnnL = 1'b0;
    drive(2'b11, 21);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_hold_ready%0d", k), 64'(req_ready), 64'd0);
      check_slot($sformatf("bp_hold%0d", k), 0, 20);
      step();
    end
    halt_RnnnnL = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'd2);
    step();
    check_slot("bp_next", 1, 21);
    check("bp_count", 64'(tri_count), 64'd7);

    // Config drain with a halt mid-drain restarting the count.
    drive(2'b01, 30);
    cfg_valid = 1'b1;
    cfg_screen[1] = 24'd1024;
    cfg_screen[0] = 24'd768;
    cfg_subSample = 4'd4;
    #1;
    check("cfg_enter_ready", 64'(req_ready), 64'd1);
    step();
    check_slot("cfg_slot", 0, 30);
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 40 + i);
      halt_RnnnnL = (i == 3) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("drain_ready%0d", i), 64'(req_ready), 64'd0);
      check($sformatf("drain_cfg_ready%0d", i), 64'(cfg_ready), 64'd0);
      step();
    end
    halt_RnnnnL = 1'b1;
    drive(2'b11, 50);
    #1;
    check("apply_cfg_ready", 64'(cfg_ready), 64'd1);
    check("apply_ready", 64'(req_ready), 64'd0);
    check("apply_old_screen", 64'(screen_RnnnnS[1]), 64'd0);
    step();
    cfg_valid = 1'b0;
    drive(2'b11, 51);
    #1;
    check("post_cfg_ready", 64'(cfg_ready), 64'd0);
    check("post_screen_x", 64'(screen_RnnnnS[1]), 64'd1024);
    check("post_screen_y", 64'(screen_RnnnnS[0]), 64'd768);
    check("post_sub", 64'(subSample_RnnnnU), 64'd4);
    check("post_grant", 64'(req_ready), 64'd2);
    step();
    check_slot("post_slot", 1, 51);

    // tri_count wraps when the slot is consumed at all-ones.
    drive(2'b00, 0);
    force dut.tri_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.tri_count_q;
    #1;
    check("wrap_pre", 64'(tri_count), 64'hFFFF_FFFF);
    step();
    check("wrap_post", 64'(tri_count), 64'd0);
    check("wrap_valid", 64'(validTri_R10H), 64'd0);

    // Reset while draining with a full, halted slot.
    drive(2'b01, 60);
    cfg_valid = 1'b1;
    cfg_screen[1] = 24'd5;
    cfg_screen[0] = 24'd6;
    cfg_subSample = 4'd9;
    step();
    halt_RnnnnL = 1'b0;
    #1;
    check("mid_full", 64'(validTri_R10H), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    check("mid_valid", 64'(validTri_R10H), 64'd0);
    check("mid_tri", 64'(tri_R10S[0][0]), 64'd0);
    check("mid_color", 64'(color_R10U[0]), 64'd0);
    check("mid_count", 64'(tri_count), 64'd0);
    check("mid_screen", 64'(screen_RnnnnS), 64'd0);
    check("mid_sub", 64'(subSample_RnnnnU), 64'd0);
    check("mid_cfg_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b0;
    cfg_valid = 1'b0;
    halt_RnnnnL = 1'b1;
    drive(2'b11, 70);
    #1;
    check("mid_rr_reset", 64'(req_ready), 64'd1);
    step();
    drive(2'b00, 0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("mid_no_apply%0d", k), 64'(cfg_ready), 64'd0);
      step();
    end
    check("mid_screen_kept", 64'(screen_RnnnnS), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rast_tri_sched.md
# rast_tri_sched

Front-end scheduler for the `rast` rasterizer. It arbitrates round-robin between two triangle requesters and drives one registered triangle slot into `rast`'s R10 inputs, honouring `halt_RnnnnL` backpressure. It also owns the screen/subsample configuration registers. A configuration change is applied only after the slot and the downstream pipe have drained for `DRAIN_CYCLES`.

## Interface
- `SIGFIG`, 24: bits in color and position
- `RADIX`, 10: fraction bits (carried through, not used arithmetically)
- `VERTS`, 3: vertices per triangle
- `AXIS`, 3: axes per vertex
- `COLORS`, 3: color channels
- `DRAIN_CYCLES`, 16: idle, un-halted cycles required before a config change is applied; legal range 1..255

Ports:
- `clk`  in  1: clock
- `rst`  in  1: synchronous, active-high reset
- `req_valid[1:0]`  in  2: requester i offers a triangle
- `req_ready[1:0]`  out  2: requester i's triangle is accepted this cycle (combinational)
- `req_tri[1:0][VERTS-1:0][AXIS-1:0]`  in  SIGFIG signed each: triangle vertices per requester
- `req_color[1:0][COLORS-1:0]`  in  SIGFIG unsigned each: color per requester
- `cfg_valid`  in  1: configuration change requested; must hold until `cfg_ready`
- `cfg_screen[1:0]`  in  SIGFIG signed each: new screen dimensions
- `cfg_subSample`  in  4: new subsample interval
- `cfg_ready`  out  1: one-cycle pulse; config applied
- `tri_R10S[VERTS-1:0][AXIS-1:0]`  out  SIGFIG signed: to `rast`
- `color_R10U[COLORS-1:0]`  out  SIGFIG unsigned: to `rast`
- `validTri_R10H`  out  1: to `rast`
- `halt_RnnnnL`  in  1: from `rast`; 0 means stalled and the slot must hold
- `screen_RnnnnS[1:0]`  out  SIGFIG signed: registered config to `rast`
- `subSample_RnnnnU`  out  4: registered config to `rast`
- `tri_count`  out  32: triangles handed to `rast`; wraps modulo 2^32

## Operation
- **Slot.** A single output register holds `tri_R10S`, `color_R10U` and `validTri_R10H`.
  - The slot is *consumed* on an edge where `validTri_R10H=1` and `halt_RnnnnL=1`.
  - The slot is *free* when `validTri_R10H=0` or `halt_RnnnnL=1`.
- **Grant.** Requester g is granted when the FSM is in RUN, the slot is free and `req_valid[g]=1`.
  - If both requesters are valid, g = `rr_ptr`; otherwise g is the only valid requester.
  - `req_ready[g]=1`. At the edge the slot loads requester g's data and `validTri_R10H←1`. `rr_ptr←~g`.
  - At most one `req_ready` bit is high in any cycle.
- **Slot clear and hold.**
  - Slot consumed with no grant: `validTri_R10H←0`. Data may hold stale values.
  - `halt_RnnnnL=0` with `validTri_R10H=1`: all slot bits hold, and `req_ready=0`.
- **tri_count.** Increments once per consumed slot.
- **FSM states: RUN, DRAIN, APPLY.**
  - RUN: grants are allowed. If `cfg_valid=1`, go to DRAIN. The grant in that same cycle is still taken.
  - DRAIN: no grants (`req_ready=0`).
    - `drain_cnt` (8-bit) clears to 0 on any cycle with `validTri_R10H=1` or `halt_RnnnnL=0`. Otherwise it increments.
    - When `drain_cnt == DRAIN_CYCLES-1` and the increment condition holds, go to APPLY.
  - APPLY (one cycle):
    - `screen_RnnnnS←cfg_screen`, `subSample_RnnnnU←cfg_subSample`.
    - `cfg_ready=1`.
    - Next state RUN; `drain_cnt←0`.
- `cfg_valid` deasserted during DRAIN is a protocol violation; the behaviour is undefined but the block must not hang (it still completes APPLY with the current inputs).

## Timing
- **Reset values** (synchronous `rst`):
  - `validTri_R10H=0`; `tri_R10S`, `color_R10U` = 0
  - `screen_RnnnnS` = {0,0}; `subSample_RnnnnU=0`
  - `cfg_ready=0`; `tri_count=0`
  - `rr_ptr=0`; FSM=RUN; `drain_cnt=0`
  - `req_ready=0` while `rst=1`
- **Reset mid-operation.** Any in-slot triangle is dropped. A pending config is discarded and must be re-requested.
- **Latency.** Requester accept edge → triangle on `tri_R10S` at the next cycle (1 cycle). Back-to-back full throughput is sustained while `halt_RnnnnL=1`.
- **Config latency.** With the slot empty and no halt, the APPLY cycle follows `cfg_valid` rising by `DRAIN_CYCLES+1` cycles. The new config is visible on the cycle after APPLY.
- **Combinational paths.** `req_ready` is combinational from `req_valid`, `halt_RnnnnL`, slot state and FSM. All other outputs are registered.

## Test plan
- **Single requester, no halt.** Req0 sends 4 triangles on consecutive cycles → `req_ready[0]=1` on 4 consecutive cycles; `validTri_R10H=1` for 4 cycles starting 1 cycle later; data matches in order; `tri_count=4`.
- **Round-robin.** Both requesters valid continuously for 6 cycles after reset → grant order 0,1,0,1,0,1; each `req_ready` is one-hot.
- **Backpressure.** A triangle is in the slot and `halt_RnnnnL=0` for 5 cycles → `tri_R10S` stable and `req_ready=0` for those 5 cycles; on `halt_RnnnnL=1` the slot is consumed and the next grant occurs in that same cycle.
- **Config drain.** `DRAIN_CYCLES=4`, slot holds a triangle, `cfg_valid` with screen={1024,768} and subSample=4:
  - No grants occur during DRAIN.
  - A `halt_RnnnnL=0` cycle mid-drain restarts the count.
  - `cfg_ready` pulses once after 4 clean cycles.
  - `screen_RnnnnS` reads {1024,768} on the next cycle, and grants resume.
- **Wrap.** Force `tri_count=32'hFFFFFFFF` and consume one triangle → `tri_count=0`.
- **Reset mid-operation.** Assert `rst` during DRAIN with the slot full → all outputs return to their reset values the next cycle; `cfg_ready` never pulses.
